// File: rtl/exc_ctrl.sv
// exc_ctrl -- exception/interrupt arbitration stage feeding CP0.
//
// Purpose:
//   Arbitrates the synchronous exceptions reported by the decoder (SYSCALL,
//   BREAK, TEQ trap) against the external interrupts that are pending and
//   unmasked. It produces a same-cycle take-exception strobe together with
//   the ExcCode that CP0 needs. It also tracks whether a handler is running,
//   from the taken exception until ERET.
//
// Optional feature:
//   EXC_INT_EN -- when defined, the external interrupt path is built. This
//   path covers the synchronisers, edge detect, pending latches, Status
//   masking and int_id. When undefined, int_in and the Status IM bits are
//   ignored, and int_pending and int_id stay at 0.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth per int_in line (2..3)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   instr_done   current instruction completes this cycle
//   syscall      decoded SYSCALL (qualified by instr_done)
//   brk          decoded BREAK (qualified by instr_done)
//   teq_hit      TEQ with equal operands (qualified by instr_done)
//   eret         ERET executing (qualified by instr_done)
//   int_in[4:0]  asynchronous external interrupt lines, rising-edge sensitive
//   status[31:0] CP0 Status: bit 0 = IE, bits 12:8 = IM[4:0]
//   exception    combinational take-exception strobe
//   cause[4:0]   ExcCode of the winner, 0 when no exception
//   int_id[2:0]  index of the taken interrupt, 0 otherwise
//   int_pending  registered pending-interrupt latches
//   in_handler   registered; exception taken and ERET not yet seen
module exc_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_done,
  input  logic        syscall,
  input  logic        brk,
  input  logic        teq_hit,
  input  logic        eret,
  input  logic [4:0]  int_in,
  input  logic [31:0] status,
  output logic        exception,
  output logic [4:0]  cause,
  output logic [2:0]  int_id,
  output logic [4:0]  int_pending,
  output logic        in_handler
);

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_TR  = 5'd13;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        sync_any_s;
  logic        int_any_s;
  logic [2:0]  int_win_s;
  logic        exception_s;
  logic [4:0]  cause_s;
  logic [2:0]  int_id_s;

  assign sync_any_s = syscall | brk | teq_hit;

`ifdef EXC_INT_EN
  logic [4:0] sync_r [SYNC_STAGES];
  logic [4:0] sync_prev_r;
  logic [4:0] edge_s;
  logic [4:0] elig_s;
  logic [4:0] int_clr_s;
  logic [4:0] pend_r;
  logic [4:0] pend_next_s;
  logic       unused_s;

  // Return the lowest set index of an interrupt vector.
  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] idx;
    casez (v)
      5'b????1: idx = 3'd0;
      5'b???10: idx = 3'd1;
      5'b??100: idx = 3'd2;
      5'b?1000: idx = 3'd3;
      5'b10000: idx = 3'd4;
      default:  idx = 3'd0;
    endcase
    return idx;
  endfunction

  // Synchroniser chain plus the previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_r[k] <= 5'd0;
      end
      sync_prev_r <= 5'd0;
    end else begin
      sync_r[0] <= int_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_r[k] <= sync_r[k-1];
      end
      sync_prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign edge_s = sync_r[SYNC_STAGES-1] & ~sync_prev_r;

  // A pending line is eligible only when it is unmasked, IE is set and no handler is running.
  assign elig_s    = pend_r & status[12:8] & {5{status[0]}} & {5{state_r == IDLE}};
  assign int_any_s = |elig_s;
  assign int_win_s = lowest_idx(elig_s);

  // Clear the winning pending bit only when the interrupt actually wins the strobe.
  always_comb begin
    int_clr_s = 5'd0;
    if (exception_s && !sync_any_s) begin
      int_clr_s = 5'd1 << int_win_s;
    end else begin
      int_clr_s = 5'd0;
    end
  end

  // A new edge in the clearing cycle re-sets the bit, so set wins over clear.
  assign pend_next_s = (pend_r & ~int_clr_s) | edge_s;

  // Sticky pending-interrupt latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= 5'd0;
    end else begin
      pend_r <= pend_next_s;
    end
  end

  assign int_pending = pend_r;
  assign unused_s    = ^{status[31:13], status[7:1]};
`else
  logic unused_s;

  assign int_any_s   = 1'b0;
  assign int_win_s   = 3'd0;
  assign int_pending = 5'd0;
  assign unused_s    = ^{int_in, status, SYNC_STAGES[0]};
`endif

  // Arbitration: syscall > brk > teq_hit > lowest eligible interrupt; gated off in reset.
  always_comb begin
    exception_s = rst & instr_done & ~eret & (sync_any_s | int_any_s);
    cause_s     = 5'd0;
    int_id_s    = 3'd0;
    if (exception_s) begin
      if (syscall) begin
        cause_s = EXC_SYS;
      end else if (brk) begin
        cause_s = EXC_BP;
      end else if (teq_hit) begin
        cause_s = EXC_TR;
      end else begin
        cause_s  = EXC_INT;
        int_id_s = int_win_s;
      end
    end else begin
      cause_s  = 5'd0;
      int_id_s = 3'd0;
    end
  end

  assign exception = exception_s;
  assign cause     = cause_s;
  assign int_id    = int_id_s;

  // Handler-occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handler-occupancy next state; ERET in IDLE is ignored, nested exceptions stay in HANDLER.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (exception_s) begin
          state_next_s = HANDLER;
        end else begin
          state_next_s = IDLE;
        end
      end
      HANDLER: begin
        if (exception_s) begin
          state_next_s = HANDLER;
        end else if (instr_done && eret) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HANDLER;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  assign in_handler = (state_r == HANDLER);

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt arbitration stage sitting directly upstream of the CP0 register file in the MIPS CPU. Collects synchronous exception requests from the decoder (SYSCALL, BREAK, TEQ trap) and five asynchronous external interrupt lines. Applies Status-register masking, prioritises, and drives the single-cycle `exception` strobe and 5-bit ExcCode that CP0 consumes to update Status/Cause/EPC. Tracks handler occupancy until ERET.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on each `int_in` line (legal 2..3).
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `instr_done`  input  1  current instruction completes this cycle; exceptions are taken only here.
- `syscall`  input  1  decoded SYSCALL, qualified by `instr_done`.
- `brk`  input  1  decoded BREAK, qualified by `instr_done`.
- `teq_hit`  input  1  TEQ executed with equal operands, qualified by `instr_done`.
- `eret`  input  1  ERET executing, qualified by `instr_done`.
- `int_in`  input  5  external interrupt lines, asynchronous, rising-edge sensitive.
- `status`  input  32  CP0 Status: bit 0 = IE, bits 12:8 = IM[4:0].
- `exception`  output  1  take-exception strobe to CP0, combinational.
- `cause`  output  5  ExcCode to CP0; 0 when `exception`=0.
- `int_id`  output  3  index of the interrupt taken; 0 unless interrupt taken.
- `int_pending`  output  5  registered pending-interrupt latches.
- `in_handler`  output  1  registered; exception taken, ERET not yet seen.

## Operation
- ExcCodes: interrupt = 5'd0, SYSCALL = 5'd8, BREAK = 5'd9, TEQ trap = 5'd13.
- Each `int_in[i]` passes through a `SYNC_STAGES`-flop synchroniser, then a rising-edge detector. A detected edge sets `int_pending[i]`, which is sticky until taken.
- Interrupt `i` is eligible when all of these hold: `int_pending[i]`, `status[0]`, `status[8+i]`, and `in_handler`=0.
- Priority, highest first: `syscall` > `brk` > `teq_hit` > eligible interrupt with the lowest index.
- `exception` = `instr_done` & (`syscall` | `brk` | `teq_hit` | any eligible interrupt) & ~`eret`. When it fires, `cause`/`int_id` reflect the winner.
- Synchronous exceptions are taken regardless of `in_handler` (nested SYSCALL inside a handler is legal).
- An interrupt loses to a simultaneous synchronous exception. Its pending bit stays set.
- State machine (one register, `in_handler`):
  - IDLE → HANDLER on `exception`.
  - HANDLER → IDLE on `instr_done` & `eret`.
  - HANDLER stays in HANDLER on a further `exception`.
  - `eret` in IDLE is ignored.
- Pending clear: the taken interrupt's bit is cleared on the clock edge ending the `exception` cycle. If a new edge on the same line is detected in that cycle, set wins (bit remains 1).

## Timing
- Reset (`rst`=0, asynchronous): synchronisers, edge registers, `int_pending`, and `in_handler` clear to 0. Outputs `exception`=0, `cause`=0, `int_id`=0, `int_pending`=0, `in_handler`=0.
- Synchronous exception latency: 0 cycles. The strobe appears in the same cycle as `instr_done`, so CP0 captures the faulting PC.
- Interrupt latency from an `int_in` rising edge to `int_pending` = `SYNC_STAGES`+1 clocks. Once eligible, the strobe fires at the next `instr_done`.
- `in_handler` rises on the edge after the `exception` cycle and falls on the edge after the ERET cycle. The first `instr_done` after that can take a pending interrupt.
- `int_in` pulses shorter than one clock are not guaranteed to be caught. A level held high produces exactly one pending event.
- Reset mid-handler: all state discarded. Interrupts occurring during reset are lost.

## Configuration
- `EXC_INT_EN` defined: external interrupt path present (synchronisers, edge detect, pending latches, masking, `int_id`).
- `EXC_INT_EN` undefined: `int_in` and the `status` IM bits are ignored. `int_pending`=0 and `int_id`=0 constantly. Only SYSCALL/BREAK/TEQ are arbitrated; all other behaviour is unchanged.

## Test plan
- SYSCALL: `syscall`=1, `instr_done`=1 → same cycle `exception`=1, `cause`=8. Next cycle `in_handler`=1, `exception`=0, `cause`=0.
- Interrupt: `status`=32'h0000_0401, `int_in[2]` rises → `int_pending`=5'b00100 after 3 clocks. Next `instr_done` → `exception`=1, `cause`=0, `int_id`=2. Following cycle `int_pending`=0.
- Masking: `status`=32'h0000_0400, `int_in[2]` rises → pending set, no `exception` on `instr_done`. Write `status`=32'h0000_0401 → fires at next `instr_done`, `int_id`=2.
- Collision: `int_pending[0]`=1 and enabled, `brk`=1 with `instr_done` → `cause`=9, `int_pending[0]` still 1. After ERET, next `instr_done` → `cause`=0, `int_id`=0.
- Handler blocking: in HANDLER with `int_pending[1]` enabled → no strobe. `syscall` in handler → `cause`=8, `in_handler` stays 1. `eret` → `in_handler`=0 next cycle.
- Reset mid-handler: `in_handler`=1, `int_pending`=5'b10010, assert `rst`=0 → all outputs 0 immediately, without waiting for a clock edge.
